com_sequencer: RTL and testbench

COM_SEQUENCER -- requirements
Module: com_sequencer

---
 rtl/com_sequencer.sv | 165 ++++++++++++++++
 tb/tb_com_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/com_sequencer.sv
// rtl/com_sequencer.sv - frame sequencer around a center_of_mass unit with timeout and motion direction
module com_sequencer #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int DEADBAND       = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    input  logic        frame_start_in,
    input  logic        frame_done_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        mask_in,
    output logic [10:0] com_x_out,
    output logic [9:0]  com_y_out,
    output logic        com_valid_out,
    output logic        com_tabulate_out,
    input  logic [10:0] com_x_in,
    input  logic [9:0]  com_y_in,
    input  logic        com_valid_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        valid_out,
    output logic        no_object_out,
    output logic        dir_out,
    output logic        dir_change_out,
    output logic [7:0]  drop_count_out
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCUM  = 3'd1;
    localparam logic [2:0] S_TAB    = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;

    localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic signed [11:0] DB    = 12'(DEADBAND);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [10:0]   pix_x_q, pix_x_d, cap_x_q, cap_x_d, x_q, x_d;
    logic [9:0]    pix_y_q, pix_y_d, cap_y_q, cap_y_d, y_q, y_d;
    logic          pix_v_q, pix_v_d;
    logic          valid_q, valid_d, noobj_q, noobj_d;
    logic          dir_q, dir_d, dirch_q, dirch_d, first_q, first_d;
    logic [7:0]    drop_q, drop_d;
    logic          start_ok, fwd;
    logic signed [11:0] dx;

    assign start_ok = frame_start_in && enable_in && (state_q == S_IDLE);
    assign dx       = $signed({1'b0, cap_x_q}) - $signed({1'b0, x_q});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_x_d = cap_x_q;
        cap_y_d = cap_y_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        first_d = first_q;
        drop_d  = drop_q;
        valid_d = 1'b0;
        noobj_d = 1'b0;
        dirch_d = 1'b0;
        fwd     = 1'b0;
        if (frame_start_in && !start_ok && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_ACCUM;
                    fwd     = 1'b1;
                end
            end
            S_ACCUM: begin
                // The done strobe follows the last pixel, so its own cycle is not forwarded
                if (frame_done_in) state_d = S_TAB;
                else               fwd     = 1'b1;
            end
            S_TAB: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (com_valid_in) begin
                    cap_x_d = com_x_in;
                    cap_y_d = com_y_in;
                    state_d = S_UPDATE;
                end else if (cnt_q == CNT_LAST) begin
                    noobj_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_UPDATE: begin
                x_d     = cap_x_q;
                y_d     = cap_y_q;
                valid_d = 1'b1;
                first_d = 1'b0;
                // No previous centroid exists for the first result, so direction is left alone
                if (!first_q) begin
                    if (dx > DB)       dir_d = 1'b1;
                    else if (dx < -DB) dir_d = 1'b0;
                end
                dirch_d = (dir_d != dir_q);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        pix_v_d = fwd ? mask_in : 1'b0;
        pix_x_d = fwd ? hcount_in : pix_x_q;
        pix_y_d = fwd ? vcount_in : pix_y_q;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pix_x_q <= '0;
            pix_y_q <= '0;
            pix_v_q <= 1'b0;
            cap_x_q <= '0;
            cap_y_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            noobj_q <= 1'b0;
            dir_q   <= 1'b0;
            dirch_q <= 1'b0;
            first_q <= 1'b1;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pix_x_q <= pix_x_d;
            pix_y_q <= pix_y_d;
            pix_v_q <= pix_v_d;
            cap_x_q <= cap_x_d;
            cap_y_q <= cap_y_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            noobj_q <= noobj_d;
            dir_q   <= dir_d;
            dirch_q <= dirch_d;
            first_q <= first_d;
            drop_q  <= drop_d;
        end
    end

    assign com_x_out        = pix_x_q;
    assign com_y_out        = pix_y_q;
    assign com_valid_out    = pix_v_q;
    assign com_tabulate_out = (state_q == S_TAB);
    assign x_out            = x_q;
    assign y_out            = y_q;
    assign valid_out        = valid_q;
    assign no_object_out    = noobj_q;
    assign dir_out          = dir_q;
    assign dir_change_out   = dirch_q;
    assign drop_count_out   = drop_q;
endmodule

// File: tb/tb_com_sequencer.sv
// tb/tb_com_sequencer.sv - randomized scheduled-expectation bench for com_sequencer
module tb_com_sequencer;
    localparam int T  = 256;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst_n, en, fs, fd, mask, cvi;
    logic [10:0] hc, cxi;
    logic [9:0]  vc, cyi;
    logic [10:0] com_x_out, x_out;
    logic [9:0]  com_y_out, y_out;
    logic        com_valid_out, com_tabulate_out, valid_out, no_object_out, dir_out, dir_change_out;
    logic [7:0]  drop_count_out;

    always #5 clk = ~clk;

    com_sequencer #(.TIMEOUT_CYCLES(T), .DEADBAND(DB)) dut (
        .clk_in(clk), .rst_in(rst_n), .enable_in(en), .frame_start_in(fs), .frame_done_in(fd),
        .hcount_in(hc), .vcount_in(vc), .mask_in(mask),
        .com_x_out(com_x_out), .com_y_out(com_y_out), .com_valid_out(com_valid_out),
        .com_tabulate_out(com_tabulate_out),
        .com_x_in(cxi), .com_y_in(cyi), .com_valid_in(cvi),
        .x_out(x_out), .y_out(y_out), .valid_out(valid_out), .no_object_out(no_object_out),
        .dir_out(dir_out), .dir_change_out(dir_change_out), .drop_count_out(drop_count_out)
    );

    int cyc = 0, tests = 0, fails = 0;
    // Expected events keyed by the cycle in which they must be visible
    bit e_cv[int], e_tab[int], e_noobj[int], e_valid[int], e_dirch[int], e_reset[int], e_dir[int];
    int e_px[int], e_py[int], e_xu[int], e_yu[int], e_drop[int];
    int m_x = 0, m_y = 0, m_dir = 0, m_drop = 0;
    int n_cv = 0, n_tab = 0, n_dirch = 0;
    int d_x = 0, d_dir = 0;
    bit d_first = 1'b1;
    int last_tab = 0;
    int q_h[$], q_v[$], q_m[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (e_reset.exists(cyc)) begin
                m_x = 0; m_y = 0; m_dir = 0; m_drop = 0;
            end
            if (e_drop.exists(cyc)) m_drop = (m_drop + e_drop[cyc] > 255) ? 255 : m_drop + e_drop[cyc];
            if (e_xu.exists(cyc)) begin m_x = e_xu[cyc]; m_y = e_yu[cyc]; end
            if (e_dir.exists(cyc)) m_dir = e_dir[cyc];
            chk("com_valid_out", com_valid_out, e_cv.exists(cyc) ? e_cv[cyc] : 0);
            if (e_cv.exists(cyc) && e_cv[cyc]) begin
                chk("com_x_out", com_x_out, e_px[cyc]);
                chk("com_y_out", com_y_out, e_py[cyc]);
            end
            chk("com_tabulate_out", com_tabulate_out, e_tab.exists(cyc) ? 1 : 0);
            chk("no_object_out", no_object_out, e_noobj.exists(cyc) ? 1 : 0);
            chk("valid_out", valid_out, e_valid.exists(cyc) ? 1 : 0);
            chk("dir_change_out", dir_change_out, e_dirch.exists(cyc) ? 1 : 0);
            chk("x_out", x_out, m_x);
            chk("y_out", y_out, m_y);
            chk("dir_out", dir_out, m_dir);
            chk("drop_count_out", drop_count_out, m_drop);
            n_cv    += int'(com_valid_out);
            n_tab   += int'(com_tabulate_out);
            n_dirch += int'(dir_change_out);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1; fs = 1'b0; fd = 1'b0; cvi = 1'b0; mask = 1'b0;
    endtask

    task automatic drop_start();
        fs = 1'b1;
        e_drop[cyc+1] = e_drop.exists(cyc+1) ? e_drop[cyc+1] + 1 : 1;
    endtask

    task automatic drive_pix(input int m, input int h, input int v);
        mask = m[0]; hc = h[10:0]; vc = v[9:0];
        e_cv[cyc+1] = m[0];
        e_px[cyc+1] = h;
        e_py[cyc+1] = v;
    endtask

    task automatic rand_pixels(input int n, input bit none);
        q_h.delete(); q_v.delete(); q_m.delete();
        for (int i = 0; i < n; i++) begin
            q_h.push_back($urandom_range(0, 2047));
            q_v.push_back($urandom_range(0, 1023));
            q_m.push_back(none ? 0 : $urandom_range(0, 1));
        end
    endtask

    task automatic run_frame(input int lat, input bit respond, input int rx, input int ry,
                             input bit rnd, input bit wdrop);
        int dx, nd;
        step();
        en = 1'b1; fs = 1'b1;
        drive_pix(q_m[0], q_h[0], q_v[0]);
        for (int i = 1; i < q_h.size(); i++) begin
            step();
            if (rnd) begin
                en = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) drop_start();
            end
            drive_pix(q_m[i], q_h[i], q_v[i]);
        end
        step();
        fd = 1'b1; mask = 1'b1; hc = 11'($urandom); vc = 10'($urandom);
        if (rnd && $urandom_range(0, 3) == 0) drop_start();
        e_tab[cyc+1] = 1'b1;
        last_tab = cyc + 1;
        step();
        if (rnd) begin
            cvi = 1'b1; cxi = 11'($urandom); cyi = 10'($urandom); fd = 1'b1;
            if ($urandom_range(0, 2) == 0) drop_start();
        end
        step();
        for (int w = 0; w < T; w++) begin
            if (wdrop && w == 0) drop_start();
            else if (rnd && $urandom_range(0, 15) == 0) drop_start();
            if (respond && w == lat) begin
                cvi = 1'b1; cxi = rx[10:0]; cyi = ry[9:0];
                e_valid[cyc+2] = 1'b1;
                e_xu[cyc+2] = rx;
                e_yu[cyc+2] = ry;
                if (!d_first) begin
                    dx = rx - d_x;
                    nd = d_dir;
                    if (dx > DB) nd = 1;
                    else if (dx < -DB) nd = 0;
                    if (nd != d_dir) e_dirch[cyc+2] = 1'b1;
                    e_dir[cyc+2] = nd[0];
                    d_dir = nd;
                end
                d_first = 1'b0;
                d_x = rx;
                step();
                if (rnd && $urandom_range(0, 3) == 0) drop_start();
                step();
                return;
            end
            if (!respond && w == T - 1) begin
                e_noobj[cyc+1] = 1'b1;
                step();
                return;
            end
            step();
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            en = 1'($urandom_range(0, 1));
            if (!en && $urandom_range(0, 2) == 0) drop_start();
            if ($urandom_range(0, 3) == 0) fd = 1'b1;
            if ($urandom_range(0, 3) == 0) begin cvi = 1'b1; cxi = 11'($urandom); cyi = 10'($urandom); end
        end
    endtask

    initial begin
        int rx, lat;
        rst_n = 1'b0; en = 1'b0; fs = 1'b0; fd = 1'b0; mask = 1'b0; cvi = 1'b0;
        hc = '0; vc = '0; cxi = '0; cyi = '0;
        e_reset[1] = 1'b1;
        step();
        chk("reset_drop", drop_count_out, 0);
        chk("reset_x", x_out, 0);

        // First frame: five mask pixels, result (16,7) twenty cycles after tabulate
        q_h = '{9, 10, 23, 4, 5, 18, 29, 30};
        q_v = '{7, 7, 22, 5, 5, 0, 3, 3};
        q_m = '{1, 0, 1, 1, 0, 1, 1, 0};
        run_frame(19, 1'b1, 16, 7, 1'b0, 1'b0);
        chk("lit_valid1", valid_out, 1);
        chk("lit_x1", x_out, 16);
        chk("lit_y1", y_out, 7);
        chk("lit_dir1", dir_out, 0);
        chk("lit_tab_count", n_tab, 1);
        chk("lit_cv_count", n_cv, 5);
        chk("lit_tab_to_valid", cyc - last_tab, 22);

        rand_pixels(4, 1'b0);
        run_frame(3, 1'b1, 40, 9, 1'b0, 1'b0);
        chk("lit_dir2", dir_out, 1);
        chk("lit_dirch2", dir_change_out, 1);

        rand_pixels(3, 1'b0);
        run_frame(0, 1'b1, 42, 11, 1'b0, 1'b0);
        chk("lit_dir3", dir_out, 1);
        chk("lit_dirch3", dir_change_out, 0);
        chk("lit_dirch_total", n_dirch, 1);

        rand_pixels(6, 1'b1);
        run_frame(0, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("lit_noobj", no_object_out, 1);
        chk("lit_timeout_lat", cyc - (last_tab + 1), T);
        chk("lit_x_hold", x_out, 42);

        rand_pixels(3, 1'b0);
        run_frame(7, 1'b1, 30, 5, 1'b0, 1'b1);
        chk("lit_drop_wait", drop_count_out, 1);
        chk("lit_x_after_drop", x_out, 30);

        for (int i = 0; i < 300; i++) begin
            step();
            en = 1'b0;
            drop_start();
        end
        step();
        chk("lit_drop_sat", drop_count_out, 255);

        for (int f = 0; f < 24; f++) begin
            gap($urandom_range(0, 4));
            rand_pixels($urandom_range(1, 20), 1'b0);
            rx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2047) : d_x + $urandom_range(0, 12) - 6;
            if (rx < 0) rx = 0;
            if (rx > 2047) rx = 2047;
            lat = $urandom_range(0, T - 2);
            run_frame(lat, $urandom_range(0, 4) != 0, rx, $urandom_range(0, 1023), 1'b1, 1'b0);
        end

        // Reset during ACCUM, then a normal frame
        step();
        en = 1'b1; fs = 1'b1;
        drive_pix(1, 100, 50);
        step();
        drive_pix(1, 101, 50);
        step();
        rst_n = 1'b0; mask = 1'b1; hc = 11'd102; vc = 10'd50;
        e_reset[cyc+1] = 1'b1;
        d_x = 0; d_dir = 0; d_first = 1'b1;
        step();
        chk("lit_rst_x", x_out, 0);
        chk("lit_rst_cv", com_valid_out, 0);
        chk("lit_rst_tab", com_tabulate_out, 0);
        chk("lit_rst_drop", drop_count_out, 0);
        rand_pixels(5, 1'b0);
        run_frame(5, 1'b1, 500, 300, 1'b0, 1'b0);
        chk("lit_post_rst_x", x_out, 500);
        chk("lit_post_rst_dir", dir_out, 0);
        chk("lit_post_rst_dirch", dir_change_out, 0);
        gap(3);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
